// File: rtl/instruction_loader_pkg.sv
// instruction_loader_pkg: loader state encoding and the shared HALT instruction word
package instruction_loader_pkg;
  localparam logic [31:0] HALT_INSTRUCTION = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {LDR_IDLE, LDR_LOAD, LDR_WRITE, LDR_DONE} ldr_state_t;
endpackage

// File: rtl/instruction_loader.sv
// instruction_loader: packs UART bytes big-endian into words and writes them to instruction memory from address 0
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int NB       = 32,
  parameter int NB_BYTE  = 8,
  parameter int NB_WADDR = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_rx_valid,
  input  logic [NB_BYTE-1:0]  i_rx_data,
  output logic                o_imem_we,
  output logic [NB-1:0]       o_imem_addr,
  output logic [NB-1:0]       o_imem_data,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic [NB_WADDR:0]   o_word_count
);
  localparam int NBI = $clog2(NB / NB_BYTE);
  localparam logic [NB_WADDR:0] FULL = {1'b1, {NB_WADDR{1'b0}}};
  ldr_state_t state, next;
  logic [NB-1:0] word;
  logic [NBI-1:0] byte_idx;
  logic [NB_WADDR-1:0] word_idx;
  logic halt, full, idle, accept, last;
  always_comb begin
    halt = o_imem_data == HALT_INSTRUCTION;
    full = &word_idx;
    idle = state == LDR_IDLE || state == LDR_DONE;
    accept = i_rx_valid && (state == LDR_LOAD || (state == LDR_WRITE && !halt && !full));
    last = i_rx_valid && state == LDR_LOAD && &byte_idx;
    next = idle ? (i_start ? LDR_LOAD : state) :
           state == LDR_LOAD ? (last ? LDR_WRITE : LDR_LOAD) :
           (halt || full) ? LDR_DONE : LDR_LOAD;
    o_busy = state == LDR_LOAD || state == LDR_WRITE;
    o_done = state == LDR_DONE;
  end
  always_ff @(posedge i_clk) state <= i_reset ? LDR_IDLE : next;
  // A byte arriving in WRITE becomes byte 0 of the next word unless the load is ending
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_data  <= '0;
      o_error      <= 1'b0;
      o_word_count <= '0;
      word         <= '0;
      byte_idx     <= '0;
      word_idx     <= '0;
    end else begin
      o_imem_we <= last;
      if (idle && i_start) begin
        byte_idx     <= '0;
        word_idx     <= '0;
        o_word_count <= '0;
        o_error      <= 1'b0;
      end
      if (accept) begin
        word     <= {word[NB-NB_BYTE-1:0], i_rx_data};
        byte_idx <= byte_idx + NBI'(1);
      end
      if (last) begin
        o_imem_addr <= NB'({word_idx, 2'b00});
        o_imem_data <= {word[NB-NB_BYTE-1:0], i_rx_data};
      end
      if (state == LDR_WRITE) begin
        word_idx <= word_idx + NB_WADDR'(1);
        if (o_word_count != FULL) o_word_count <= o_word_count + (NB_WADDR+1)'(1);
        if (!halt && full) o_error <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: random and directed loads on a 256-word and a 4-word loader against a byte-queue model
module tb_instruction_loader;
  logic clk = 1'b0;
  logic i_reset, i_start, rx_valid;
  logic [7:0] rx_data;
  logic b_we, b_busy, b_done, b_err;
  logic [31:0] b_addr, b_data;
  logic [8:0] b_cnt;
  logic s_we, s_busy, s_done, s_err;
  logic [31:0] s_addr, s_data;
  logic [2:0] s_cnt;
  int checks = 0;
  int errors = 0;
  int depth [2] = '{256, 4};
  bit m_busy [2], m_done [2], m_err [2], m_we [2];
  int m_cnt [2], m_nb [2];
  logic [31:0] m_addr [2], m_data [2];
  logic [7:0] m_buf [2][4];

  always #5 clk = ~clk;

  instruction_loader #(.NB(32), .NB_BYTE(8), .NB_WADDR(8)) u_big (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .o_imem_we(b_we), .o_imem_addr(b_addr), .o_imem_data(b_data), .o_busy(b_busy),
    .o_done(b_done), .o_error(b_err), .o_word_count(b_cnt));

  instruction_loader #(.NB(32), .NB_BYTE(8), .NB_WADDR(2)) u_small (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .o_imem_we(s_we), .o_imem_addr(s_addr), .o_imem_data(s_data), .o_busy(s_busy),
    .o_done(s_done), .o_error(s_err), .o_word_count(s_cnt));

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(int i, bit rst, bit st, bit v, logic [7:0] d);
    bit b0, was, ended;
    if (rst) begin
      m_busy[i] = 0; m_done[i] = 0; m_err[i] = 0; m_we[i] = 0;
      m_cnt[i] = 0; m_nb[i] = 0; m_addr[i] = '0; m_data[i] = '0;
      return;
    end
    b0 = m_busy[i];
    was = m_we[i];
    ended = 0;
    m_we[i] = 0;
    if (was) begin
      if (m_cnt[i] < depth[i]) m_cnt[i]++;
      if (m_data[i] == 32'hFFFF_FFFF || m_cnt[i] == depth[i]) begin
        ended = 1;
        if (m_data[i] != 32'hFFFF_FFFF) m_err[i] = 1;
        m_busy[i] = 0;
        m_done[i] = 1;
      end
    end else if (!b0 && st) begin
      m_busy[i] = 1; m_done[i] = 0; m_err[i] = 0; m_cnt[i] = 0; m_nb[i] = 0;
    end
    if (b0 && !ended && v) begin
      m_buf[i][m_nb[i]] = d;
      m_nb[i]++;
      if (m_nb[i] == 4) begin
        m_we[i] = 1;
        m_addr[i] = 32'(m_cnt[i] * 4);
        m_data[i] = {m_buf[i][0], m_buf[i][1], m_buf[i][2], m_buf[i][3]};
        m_nb[i] = 0;
      end
    end
  endtask

  task automatic cyc(bit rst, bit st, bit v, logic [7:0] d);
    i_reset = rst; i_start = st; rx_valid = v; rx_data = d;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i, rst, st, v, d);
    #1;
    check("b_we", 64'(b_we), 64'(m_we[0]));
    check("b_addr", 64'(b_addr), 64'(m_addr[0]));
    check("b_data", 64'(b_data), 64'(m_data[0]));
    check("b_busy", 64'(b_busy), 64'(m_busy[0]));
    check("b_done", 64'(b_done), 64'(m_done[0]));
    check("b_error", 64'(b_err), 64'(m_err[0]));
    check("b_count", 64'(b_cnt), 64'(m_cnt[0]));
    check("s_we", 64'(s_we), 64'(m_we[1]));
    check("s_addr", 64'(s_addr), 64'(m_addr[1]));
    check("s_data", 64'(s_data), 64'(m_data[1]));
    check("s_busy", 64'(s_busy), 64'(m_busy[1]));
    check("s_done", 64'(s_done), 64'(m_done[1]));
    check("s_error", 64'(s_err), 64'(m_err[1]));
    check("s_count", 64'(s_cnt), 64'(m_cnt[1]));
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 8'h00);
  endtask

  task automatic send_word(logic [31:0] w, int gap);
    for (int k = 3; k >= 0; k--) begin
      cyc(0, 0, 1, w[k*8 +: 8]);
      idle(gap);
    end
  endtask

  function automatic logic [31:0] rand_word();
    return {8'($urandom_range(0, 254)), 24'($urandom)};
  endfunction

  initial begin
    i_reset = 1'b1; i_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    cyc(1, 0, 0, 8'h00);
    cyc(1, 0, 0, 8'h00);
    idle(2);
    cyc(0, 1, 0, 8'h00);
    send_word(32'h2008_0005, 1);
    send_word(32'hFFFF_FFFF, 1);
    idle(3);
    check("dir_done", 64'(b_done), 64'd1);
    check("dir_count", 64'(b_cnt), 64'd2);
    cyc(0, 1, 0, 8'h00);
    for (int k = 0; k < 3; k++) send_word(rand_word(), 0);
    send_word(32'hFFFF_FFFF, 0);
    idle(3);
    cyc(0, 1, 0, 8'h00);
    for (int k = 0; k < 17; k++) cyc(0, 0, 1, 8'($urandom_range(0, 254)));
    idle(3);
    check("full_err", 64'(s_err), 64'd1);
    cyc(0, 0, 1, 8'h12);
    cyc(0, 0, 1, 8'h34);
    cyc(1, 0, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);
    send_word(32'h0000_0000, 0);
    idle(2);
    cyc(1, 0, 0, 8'h00);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 8'($urandom));
    cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 1, 8'hA1);
    cyc(0, 0, 1, 8'hB2);
    cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 1, 8'hC3);
    cyc(0, 0, 1, 8'hD4);
    send_word(32'hFFFF_FFFF, 0);
    idle(2);
    cyc(0, 1, 0, 8'h00);
    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1,
          8'(($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 255)));
    cyc(0, 1, 0, 8'h00);
    idle(2);
    cyc(0, 1, 0, 8'h00);
    for (int k = 0; k < 1030; k++) cyc(0, 0, 1, 8'($urandom_range(0, 254)));
    idle(4);
    check("big_full_err", 64'(b_err), 64'd1);
    check("big_full_count", 64'(b_cnt), 64'd256);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
